instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry {pc, instr} buffer.
// Redirects flush the buffer; a request already in flight is drained and its data dropped.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [31:0] pc_mem_q [2];
    logic [31:0] pc_mem_d [2];
    logic [31:0] data_mem_q [2];
    logic [31:0] data_mem_d [2];

    logic        ack_take;
    logic        push;
    logic        pop;
    logic        tail;
    logic        outstanding_after;
    logic        issue;
    logic [31:0] base_pc;

    // Low address bits of a redirect target are ignored; fetches are word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        head_d     = head_q;
        pc_mem_d   = pc_mem_q;
        data_mem_d = data_mem_q;

        // An ack only counts while a request is in flight.
        ack_take = imem_ack && (state_q != StIdle);
        push     = ack_take && (state_q == StReq) && !redirect;
        pop      = (count_q != 2'd0) && instr_ready && !redirect;
        tail     = head_q ^ count_q[0];

        if (push) begin
            pc_mem_d[tail]   = addr_q;
            data_mem_d[tail] = imem_rdata;
        end

        if (redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + 2'(push) - 2'(pop);
        end

        if (pop) begin
            head_d = ~head_q;
        end

        outstanding_after = (state_q != StIdle) && !ack_take;
        base_pc           = redirect ? {redirect_pc[31:2], 2'b00} : fetch_pc_q;
        issue             = !outstanding_after && (count_d != 2'd2);

        if (redirect) begin
            fetch_pc_d = base_pc;
        end

        if (issue) begin
            req_d      = 1'b1;
            addr_d     = base_pc;
            fetch_pc_d = base_pc + 32'd4;
            state_d    = StReq;
        end else if (ack_take) begin
            // Buffer full after this push: park until the core drains an entry.
            req_d   = 1'b0;
            state_d = StIdle;
        end else if (redirect && (state_q == StReq)) begin
            state_d = StDiscard;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            addr_q        <= RESET_PC;
            req_q         <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            pc_mem_q[0]   <= 32'h0;
            pc_mem_q[1]   <= 32'h0;
            data_mem_q[0] <= Nop;
            data_mem_q[1] <= Nop;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            count_q    <= count_d;
            head_q     <= head_d;
            pc_mem_q   <= pc_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != 2'd0);
    assign instruction = instr_valid ? data_mem_q[head_q] : Nop;
    assign instr_pc    = instr_valid ? pc_mem_q[head_q] : 32'h0;

endmodule
